// File: rtl/patch_sum_collector_pkg.sv
// Shared constants for the patch sum collector: message type codes, field
// positions of the 64-bit result word, FSM state encoding and a log2 helper.
package patch_sum_collector_pkg;

  localparam int MSG_W = 64;

  localparam logic [2:0] MSG_TYPE_SUM = 3'b001;
  localparam logic [2:0] MSG_TYPE_EOF = 3'b111;

  // Message type occupies the top three bits of every word
  localparam int TYPE_MSB = 63;
  localparam int TYPE_LSB = 61;

  // Stall statistics field inside the EOF word
  localparam int STALL_LSB = 32;
  localparam int STALL_W   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Index width needed to address n items (at least one bit)
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/patch_sum_collector_rr_arbiter.sv
// Combinational N-way round-robin pick: returns the first requester at or
// after ptr (wrapping N-1 -> 0) and whether any request is present.
module patch_sum_collector_rr_arbiter
  import patch_sum_collector_pkg::*;
#(
  parameter int N  = 6,
  parameter int IW = log2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  // rot[k] is the request of the reducer k positions after ptr
  logic [N-1:0]  rot;
  logic [IW-1:0] first;
  logic [IW:0]   gsum;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [IW:0] raw;
      logic [IW:0] wrapped;
      assign raw     = {1'b0, ptr} + (IW+1)'(gi);
      assign wrapped = (raw >= (IW+1)'(N)) ? raw - (IW+1)'(N) : raw;
      assign rot[gi] = req[wrapped[IW-1:0]];
    end
  endgenerate

  // Lowest rotated position wins; scan downward so the last hit is the lowest
  always_comb begin
    first   = '0;
    any_req = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        first   = IW'(k);
        any_req = 1'b1;
      end
    end
  end

  assign gsum  = {1'b0, ptr} + {1'b0, first};
  assign grant = (gsum >= (IW+1)'(N)) ? IW'(gsum - (IW+1)'(N)) : gsum[IW-1:0];

endmodule

// File: rtl/patch_sum_collector.sv
// Collects finished patch sums from the PatchReducer array, packs them into
// 64-bit messages for xb_rd_fifo and emits an EOF message with the patch
// count when a frame completes.
// Optional build macro PATCH_COLLECTOR_STALL_STATS_EN adds a 16-bit
// saturating FIFO-stall counter reported in EOF bits [47:32].
module patch_sum_collector
  import patch_sum_collector_pkg::*;
#(
  parameter int N_PATCH_REDUCER = 6,
  parameter int PATCH_ID_SIZE   = 17,
  parameter int PATCH_SUM_SIZE  = 44,
  parameter int COUNT_SIZE      = 32
) (
  input  logic                                  dram_clk,
  input  logic                                  reset,
  input  logic [N_PATCH_REDUCER-1:0]            sum_rdy,
  output logic [N_PATCH_REDUCER-1:0]            sum_ack,
  input  logic [N_PATCH_REDUCER*PATCH_SUM_SIZE-1:0] sum_flat,
  input  logic [N_PATCH_REDUCER*PATCH_ID_SIZE-1:0]  patch_id_flat,
  input  logic                                  frame_done,
  input  logic                                  fpga_msg_full,
  output logic                                  fpga_msg_valid,
  output logic [MSG_W-1:0]                      fpga_msg,
  output logic                                  error
);

  localparam int PTR_W = log2(N_PATCH_REDUCER);

  state_t                      state;
  logic [PTR_W-1:0]            rr_ptr;
  logic [PTR_W-1:0]            grant;
  logic                        any_req;
  logic [COUNT_SIZE-1:0]       patch_count;
  logic                        eof_pending;
  logic                        msg_is_sum;
  logic                        eof_consume;
  logic [MSG_W-1:0]            sum_word;
  logic [MSG_W-1:0]            eof_word;
  logic [N_PATCH_REDUCER-1:0]  ack_onehot;
  logic [PTR_W-1:0]            ptr_after;

  logic [PATCH_SUM_SIZE-1:0]   sum_arr [N_PATCH_REDUCER];
  logic [PATCH_ID_SIZE-1:0]    id_arr  [N_PATCH_REDUCER];

  genvar gi;
  generate
    for (gi = 0; gi < N_PATCH_REDUCER; gi++) begin : g_unpack
      assign sum_arr[gi] = sum_flat[gi*PATCH_SUM_SIZE +: PATCH_SUM_SIZE];
      assign id_arr[gi]  = patch_id_flat[gi*PATCH_ID_SIZE +: PATCH_ID_SIZE];
    end
  endgenerate

  patch_sum_collector_rr_arbiter #(
    .N  (N_PATCH_REDUCER),
    .IW (PTR_W)
  ) u_arb (
    .req     (sum_rdy),
    .ptr     (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  assign ack_onehot  = N_PATCH_REDUCER'(1) << grant;
  assign ptr_after   = (grant == PTR_W'(N_PATCH_REDUCER - 1)) ? '0 : grant + PTR_W'(1);
  assign eof_consume = (state == ST_IDLE) && eof_pending;

`ifdef PATCH_COLLECTOR_STALL_STATS_EN
  logic [STALL_W-1:0] stall_count;

  // Count cycles the FIFO refuses a pending word; restart when an EOF is loaded
  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (eof_consume) begin
      stall_count <= '0;
    end else if (fpga_msg_valid && fpga_msg_full && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_W'(1);
    end
  end
`endif

  // Assemble candidate SUM and EOF words (COUNT_SIZE is at most 32)
  always_comb begin
    sum_word                                       = '0;
    sum_word[TYPE_MSB:TYPE_LSB]                    = MSG_TYPE_SUM;
    sum_word[PATCH_SUM_SIZE +: PATCH_ID_SIZE]      = id_arr[grant];
    sum_word[PATCH_SUM_SIZE-1:0]                   = sum_arr[grant];
    eof_word                                       = '0;
    eof_word[TYPE_MSB:TYPE_LSB]                    = MSG_TYPE_EOF;
    eof_word[COUNT_SIZE-1:0]                       = patch_count;
`ifdef PATCH_COLLECTOR_STALL_STATS_EN
    eof_word[STALL_LSB +: STALL_W]                 = stall_count;
`endif
  end

  // Frame completion bookkeeping; a request arriving while one is still
  // outstanding is dropped and flagged, unless IDLE is taking the old one now
  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      eof_pending <= 1'b0;
      error       <= 1'b0;
    end else if (frame_done) begin
      if (eof_pending && !eof_consume) error <= 1'b1;
      else                             eof_pending <= 1'b1;
    end else if (eof_consume) begin
      eof_pending <= 1'b0;
    end
  end

  // Collector FSM: pick EOF or a granted sum in IDLE, present it in SEND
  // (valid rises the cycle after the ack) and hold it until the FIFO takes it
  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      sum_ack        <= '0;
      fpga_msg_valid <= 1'b0;
      fpga_msg       <= '0;
      rr_ptr         <= '0;
      patch_count    <= '0;
      msg_is_sum     <= 1'b0;
    end else begin
      sum_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (eof_pending) begin
            fpga_msg    <= eof_word;
            msg_is_sum  <= 1'b0;
            patch_count <= '0;
            state       <= ST_SEND;
          end else if (any_req) begin
            fpga_msg    <= sum_word;
            msg_is_sum  <= 1'b1;
            sum_ack     <= ack_onehot;
            rr_ptr      <= ptr_after;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!fpga_msg_valid) begin
            fpga_msg_valid <= 1'b1;
          end else if (!fpga_msg_full) begin
            fpga_msg_valid <= 1'b0;
            state          <= ST_IDLE;
            if (msg_is_sum && (patch_count != '1))
              patch_count <= patch_count + COUNT_SIZE'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_patch_sum_collector.sv
// Self-checking bench for patch_sum_collector: a table of single-sum
// vectors, hand-written multi-cycle sequences (round robin, backpressure,
// EOF ordering, overrun, asynchronous reset) and a randomized run checked
// against a round-robin/FIFO reference model.
module tb_patch_sum_collector;

  localparam int N  = 6;
  localparam int IW = 17;
  localparam int SW = 44;

  logic              dram_clk = 1'b0;
  logic              reset;
  logic [N-1:0]      sum_rdy;
  logic [N-1:0]      sum_ack;
  logic [N*SW-1:0]   sum_flat;
  logic [N*IW-1:0]   patch_id_flat;
  logic              frame_done;
  logic              fpga_msg_full;
  logic              fpga_msg_valid;
  logic [63:0]       fpga_msg;
  logic              error;

  always #5 dram_clk = ~dram_clk;

  patch_sum_collector dut (
    .dram_clk       (dram_clk),
    .reset          (reset),
    .sum_rdy        (sum_rdy),
    .sum_ack        (sum_ack),
    .sum_flat       (sum_flat),
    .patch_id_flat  (patch_id_flat),
    .frame_done     (frame_done),
    .fpga_msg_full  (fpga_msg_full),
    .fpga_msg_valid (fpga_msg_valid),
    .fpga_msg       (fpga_msg),
    .error          (error)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0]  wr_q[$];
  logic [N-1:0] rdy_before;
  logic [SW-1:0] rs  [N];
  logic [IW-1:0] rid [N];

  // random-run model state
  int          model_ptr;
  logic [63:0] exp_sums[$];
  int          frames_issued;
  int          eofs_seen;
  int          sums_since;

  typedef struct {
    int          red;
    logic [43:0] s;
    logic [16:0] id;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [63:0] sum_msg(input logic [43:0] s, input logic [16:0] id);
    return (64'd1 << 61) | (64'(id) << 44) | 64'(s);
  endfunction

  function automatic logic [63:0] eof_msg(input int cnt);
    return (64'd7 << 61) | 64'(unsigned'(cnt));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic set_red(input int i, input logic [43:0] s, input logic [16:0] id);
    rs[i]  = s;
    rid[i] = id;
    sum_flat[i*SW +: SW]      = s;
    patch_id_flat[i*IW +: IW] = id;
  endtask

  // Advance one clock; record the word the FIFO took and check hold rules
  task automatic step();
    logic        acc;
    logic        pv;
    logic [63:0] pm;
    acc = fpga_msg_valid && !fpga_msg_full;
    pv  = fpga_msg_valid;
    pm  = fpga_msg;
    rdy_before = sum_rdy;
    @(posedge dram_clk);
    #1;
    if (acc) wr_q.push_back(pm);
    if (pv && !acc) begin
      check("hold_valid", fpga_msg_valid, 1);
      check("hold_msg", fpga_msg, pm);
    end
  endtask

  task automatic wait_ack(output int g);
    g = -1;
    for (int c = 0; c < 40 && g < 0; c++) begin
      step();
      for (int i = 0; i < N; i++) if (sum_ack[i]) g = i;
    end
    if (g < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no sum_ack within 40 cycles, required one");
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    sum_rdy       = '0;
    frame_done    = 1'b0;
    fpga_msg_full = 1'b0;
    repeat (2) @(posedge dram_clk);
    #1;
    reset = 1'b0;
    wr_q.delete();
  endtask

  // Reference model step for the randomized run
  task automatic process_random();
    logic [63:0] w;
    logic [63:0] mask;
    int g;
    int pick;
    mask = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef PATCH_COLLECTOR_STALL_STATS_EN
    mask[47:32] = 16'h0;
`endif
    if (|sum_ack) begin
      check("rand_ack_onehot", $countones(sum_ack), 1);
      g = -1;
      for (int i = 0; i < N; i++) if (sum_ack[i] && g < 0) g = i;
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && rdy_before[(model_ptr + k) % N]) pick = (model_ptr + k) % N;
      check("rand_rr_pick", g, pick);
      model_ptr = (g + 1) % N;
      exp_sums.push_back(sum_msg(rs[g], rid[g]));
      sum_rdy[g] = 1'b0;
    end
    while (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      if (w[63:61] == 3'b001) begin
        if (exp_sums.size() == 0) begin
          check("rand_unexpected_sum", w, 64'h0);
        end else begin
          check("rand_sum_word", w, exp_sums.pop_front());
        end
        sums_since++;
      end else begin
        check("rand_eof_word", w & mask, eof_msg(sums_since));
        eofs_seen++;
        sums_since = 0;
      end
    end
  endtask

  initial begin
    int g;
    int n_eof;
    logic [63:0] hold;
    logic [63:0] r;

    vecs[0] = '{2, 44'h123,          17'h5,     64'h2000_5000_0000_0123};
    vecs[1] = '{0, 44'hFFF_FFFF_FFFF, 17'h1FFFF, 64'h3FFF_FFFF_FFFF_FFFF};
    vecs[2] = '{5, 44'h0,            17'h0,     64'h2000_0000_0000_0000};
    vecs[3] = '{3, 44'hABC_DEF0_1234, 17'h10001, 64'h3000_1ABC_DEF0_1234};

    sum_flat      = '0;
    patch_id_flat = '0;
    for (int i = 0; i < N; i++) set_red(i, 44'h0, 17'h0);

    // reset state
    reset = 1'b1; sum_rdy = '0; frame_done = 1'b0; fpga_msg_full = 1'b0;
    @(posedge dram_clk); #1;
    check("rst_ack", sum_ack, 0);
    check("rst_valid", fpga_msg_valid, 0);
    check("rst_msg", fpga_msg, 0);
    check("rst_error", error, 0);
    do_reset();

    // table: single sums, one-cycle ack, valid next cycle, written after
    for (int v = 0; v < 4; v++) begin
      set_red(vecs[v].red, vecs[v].s, vecs[v].id);
      sum_rdy[vecs[v].red] = 1'b1;
      step();
      check("tbl_ack", sum_ack, 64'(1) << vecs[v].red);
      check("tbl_valid_at_ack", fpga_msg_valid, 0);
      sum_rdy[vecs[v].red] = 1'b0;
      step();
      check("tbl_ack_pulse", sum_ack, 0);
      check("tbl_valid", fpga_msg_valid, 1);
      check("tbl_msg", fpga_msg, vecs[v].exp);
      step();
      check("tbl_written", wr_q.size(), 1);
      if (wr_q.size() > 0) check("tbl_written_word", wr_q[0], vecs[v].exp);
      check("tbl_valid_drop", fpga_msg_valid, 0);
      wr_q.delete();
    end

    // round robin: all six held, then only 0 and 5
    do_reset();
    for (int i = 0; i < N; i++) set_red(i, 44'(i * 100 + 7), 17'(i + 1));
    sum_rdy = '1;
    for (int k = 0; k < N; k++) begin
      wait_ack(g);
      check("rr_order", g, k);
      if (g >= 0) sum_rdy[g] = 1'b0;
    end
    repeat (4) step();
    check("rr_writes", wr_q.size(), N);
    for (int k = 0; k < N && k < wr_q.size(); k++) check("rr_word", wr_q[k], sum_msg(rs[k], rid[k]));
    wr_q.delete();
    sum_rdy[0] = 1'b1; sum_rdy[5] = 1'b1;
    wait_ack(g);
    check("rr_reraise_first", g, 0);
    if (g >= 0) sum_rdy[g] = 1'b0;
    wait_ack(g);
    check("rr_reraise_second", g, 5);
    if (g >= 0) sum_rdy[g] = 1'b0;
    repeat (4) step();
    wr_q.delete();

    // backpressure: 10 full cycles, no new grant, write on release
    set_red(4, 44'h4_4444_4444, 17'h44);
    sum_rdy[4] = 1'b1;
    wait_ack(g);
    sum_rdy[4] = 1'b0;
    fpga_msg_full = 1'b1;
    step();
    check("bp_valid_up", fpga_msg_valid, 1);
    hold = sum_msg(44'h4_4444_4444, 17'h44);
    sum_rdy[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("bp_valid", fpga_msg_valid, 1);
      check("bp_msg", fpga_msg, hold);
      check("bp_no_ack", sum_ack, 0);
    end
    check("bp_no_write", wr_q.size(), 0);
    fpga_msg_full = 1'b0;
    step();
    check("bp_write", wr_q.size(), 1);
    if (wr_q.size() > 0) check("bp_word", wr_q[0], hold);
    check("bp_valid_drop", fpga_msg_valid, 0);
    wait_ack(g);
    check("bp_next_grant", g, 1);
    if (g >= 0) sum_rdy[g] = 1'b0;
    repeat (4) step();
    wr_q.delete();

    // EOF: three sums, frame_done, EOF beats the pending sum, count restarts
    do_reset();
    for (int j = 0; j < 3; j++) begin
      set_red(j, 44'(j + 1), 17'(j + 9));
      sum_rdy[j] = 1'b1;
      wait_ack(g);
      if (g >= 0) sum_rdy[g] = 1'b0;
      repeat (3) step();
    end
    check("eof_pre_writes", wr_q.size(), 3);
    wr_q.delete();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    set_red(1, 44'hBEEF, 17'h77);
    sum_rdy[1] = 1'b1;
    for (int c = 0; c < 30 && wr_q.size() < 2; c++) begin
      step();
      if (sum_ack[1]) sum_rdy[1] = 1'b0;
    end
    check("eof_writes", wr_q.size(), 2);
    if (wr_q.size() >= 2) begin
      check("eof_word", wr_q[0], 64'hE000_0000_0000_0003);
      check("eof_then_sum", wr_q[1], sum_msg(44'hBEEF, 17'h77));
    end
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    for (int c = 0; c < 20 && wr_q.size() < 3; c++) step();
    if (wr_q.size() >= 3) check("eof_restart", wr_q[2], eof_msg(1));
    else check("eof_restart_missing", wr_q.size(), 3);

    // overrun: two frame_done pulses while a word is stuck in SEND
    do_reset();
    sum_rdy[0] = 1'b1;
    wait_ack(g);
    sum_rdy[0] = 1'b0;
    fpga_msg_full = 1'b1;
    step();
    frame_done = 1'b1; step(); frame_done = 1'b0; step();
    check("ovr_first_ok", error, 0);
    frame_done = 1'b1; step(); frame_done = 1'b0;
    check("ovr_error", error, 1);
    fpga_msg_full = 1'b0;
    repeat (20) step();
    n_eof = 0;
    foreach (wr_q[k]) if (wr_q[k][63:61] == 3'b111) n_eof++;
    check("ovr_one_eof", n_eof, 1);
    check("ovr_sticky", error, 1);

    // asynchronous reset in the middle of SEND
    wr_q.delete();
    sum_rdy[2] = 1'b1;
    wait_ack(g);
    sum_rdy[2] = 1'b0;
    fpga_msg_full = 1'b1;
    step();
    check("arst_valid_before", fpga_msg_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", fpga_msg_valid, 0);
    check("arst_error", error, 0);
    check("arst_msg", fpga_msg, 0);
    @(posedge dram_clk); #1;
    reset = 1'b0;
    fpga_msg_full = 1'b0;
    repeat (5) step();
    check("arst_abandoned", wr_q.size(), 0);

`ifdef PATCH_COLLECTOR_STALL_STATS_EN
    // stall statistics: five full-stall cycles in one frame
    do_reset();
    set_red(3, 44'h33, 17'h3);
    sum_rdy[3] = 1'b1;
    wait_ack(g);
    sum_rdy[3] = 1'b0;
    fpga_msg_full = 1'b1;
    step();
    repeat (5) step();
    fpga_msg_full = 1'b0;
    step();
    frame_done = 1'b1; step(); frame_done = 1'b0;
    for (int c = 0; c < 20 && wr_q.size() < 2; c++) step();
    if (wr_q.size() >= 2) check("stall_eof", wr_q[1], eof_msg(1) | (64'd5 << 32));
    else check("stall_eof_missing", wr_q.size(), 2);
`endif

    // randomized run against the reference model
    do_reset();
    model_ptr = 0; frames_issued = 0; eofs_seen = 0; sums_since = 0;
    exp_sums.delete();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!sum_rdy[i] && $urandom_range(3) == 0) begin
          r = {$urandom(), $urandom()};
          set_red(i, r[43:0], r[60:44]);
          sum_rdy[i] = 1'b1;
        end
      end
      fpga_msg_full = ($urandom_range(2) == 0);
      frame_done = (frames_issued == eofs_seen) && ($urandom_range(39) == 0);
      if (frame_done) frames_issued++;
      step();
      frame_done = 1'b0;
      process_random();
    end
    fpga_msg_full = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      process_random();
    end
    check("rand_drained_sums", exp_sums.size(), 0);
    check("rand_all_acked", sum_rdy, 0);
    check("rand_eof_count", eofs_seen, frames_issued);
    check("rand_no_error", error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
